i2c_master_csr_fifo: RTL and testbench
======================================

I2C_MASTER_CSR_FIFO -- requirements
Module: i2c_master_csr_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, TX and RX FIFO depth; power of 2, range 2..64.
REQ-002 Parameter PRER_RST, default 16'hFFFF, reset value of the prescale register.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be, in this order:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- apb_sel, apb_en, apb_write  in  1 each  APB controls
- apb_addr  in  32  byte address; only [4:2] decoded
- apb_wdata  in  32  write data
- apb_rdata  out  32  read data
- apb_ready  out  1  tied 1
- irq  out  1  interrupt
- core_en  out  1  byte-controller enable
- prer  out  16  prescale
- sta, sto, rd, wr, ack  out  1 each  command bits
- txr  out  8  byte to transmit
- rxr  in  8  received byte
- done  in  1  command complete, 1-cycle pulse
- i2c_al  in  1  arbitration lost, pulse
- irxack  in  1  slave ACK bit
- i2c_busy  in  1  bus busy

Function
REQ-005 Setup phase = sel & ~en; write_en = sel & en & write; read_en = sel & en & ~write.
REQ-006 Register map by addr[4:2]:
- 0 PRER rw
- 1 CTR rw: [7] core_en, [6] gie
- 2 write pushes TXFIFO, read pops RXFIFO
- 3 write CMD, read SR
- 4 IER rw [3:0]
- 5 ISR, read / write-1-to-clear [3:0]
- 6 LVL ro: [15:8] rx_count, [7:0] tx_count
- 7 reserved: reads 0, writes ignored
REQ-007 apb_rdata SHALL be registered in the setup phase, from the addr[4:2] decode, and held through the access phase.
REQ-008 An RX pop SHALL occur on the read_en cycle; rdata SHALL carry the pre-pop head; reading an empty RXFIFO returns 0, does not pop, and sets ISR[3] (underflow).
REQ-009 A TX push when full SHALL be dropped and set ISR[3]; a push while core_en=0 is accepted.
REQ-010 FIFO counters SHALL be $clog2(FIFO_DEPTH)+1 bits; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-011 A simultaneous push and pop SHALL leave the count unchanged; when the FIFO is full, the pop takes effect first, so the push is accepted.
REQ-012 txr SHALL equal the TXFIFO head, or 0 when empty.
REQ-013 CMD bits: [7] sta, [6] sto, [5] rd, [4] wr, [3] ack, [0] iack. A CMD write SHALL be accepted only if core_en=1.
REQ-014 A CMD write with wr=1 and TXFIFO empty SHALL be rejected: cr unchanged, ISR[3] set.
REQ-015 On done with wr=1, TXFIFO SHALL pop. On done with rd=1, rxr SHALL push to RXFIFO; if RXFIFO is full the byte is dropped and ISR[3] set.
REQ-016 On done or i2c_al, cr[7:4] SHALL clear the next cycle; cr[0] SHALL self-clear one cycle after being set; a CMD write in the same cycle as done SHALL win.
REQ-017 SR SHALL read {rxack, i2c_busy, al, 3'b0, tip, irq_pending}. rxack is irxack registered. tip = rd|wr registered. al = i2c_al | (al & ~sta).
REQ-018 ISR sources:
- [0] done
- [1] i2c_al
- [2] TX level fell to empty, or RX reached full
- [3] error (under/overflow, rejected wr)
REQ-019 ISR bits SHALL be sticky. Set has priority over a same-cycle W1C. iack=1 SHALL clear all ISR bits.
REQ-020 irq_pending = |(ISR & IER). irq SHALL be registered: irq <= gie & irq_pending.
REQ-021 Clearing core_en SHALL flush both FIFOs and clear cr the next cycle; ISR is retained.

Reset
REQ-022 On rst_n low, asynchronously:
- prer=PRER_RST
- ctr, cr, IER, ISR, al, rxack, tip, irq, apb_rdata = 0
- FIFOs empty
REQ-023 Reset mid-transfer SHALL discard FIFO contents; FIFO storage RAM needs no reset.

Structure
REQ-024 A shared package i2c_master_pkg SHALL hold the register offset constants, CMD/SR/ISR bit-index constants and the default FIFO_DEPTH.
REQ-025 The FIFO SHALL be one sub-module, i2c_sync_fifo (params WIDTH, DEPTH; ports push, pop, flush, din, dout, full, empty, count), instantiated twice.

Verification
REQ-026 Bench SHALL cover:
- Reset: read PRER -> 0x0000FFFF; LVL, SR, ISR -> 0.
- Enable, IER=1, CTR=0xC0; push 0xA5, 0x3C; write CMD 0x90 -> txr=0xA5, wr=sta=1. done pulse -> txr=0x3C, cr[7:4]=0, ISR[0]=1, irq=1 two cycles after done. Write ISR 0x1 -> irq=0.
- FIFO_DEPTH=8: push 9 bytes -> LVL tx_count=8, ISR[3]=1. Then done with wr and a push in the same cycle -> count remains 8.
- rd command ×3 with rxr=0x11, 0x22, 0x33 -> reads return 0x11, 0x22, 0x33 in order. A 4th read returns 0 and sets ISR[3].
- i2c_al pulse during wr -> SR[5]=1, cr[7:4]=0, ISR[1]=1. Writing sta=1 clears SR[5] next cycle.
- rst_n asserted with 5 bytes in TXFIFO -> tx_count=0 immediately and irq=0.

Source files
------------

// File: rtl/i2c_master_pkg.sv
// i2c_master_pkg: register offsets, command/status/interrupt bit indices and defaults
package i2c_master_pkg;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam logic [2:0] ADDR_PRER = 3'd0;
  localparam logic [2:0] ADDR_CTR  = 3'd1;
  localparam logic [2:0] ADDR_DATA = 3'd2;
  localparam logic [2:0] ADDR_CMD  = 3'd3;
  localparam logic [2:0] ADDR_IER  = 3'd4;
  localparam logic [2:0] ADDR_ISR  = 3'd5;
  localparam logic [2:0] ADDR_LVL  = 3'd6;
  localparam int CMD_STA  = 7;
  localparam int CMD_STO  = 6;
  localparam int CMD_RD   = 5;
  localparam int CMD_WR   = 4;
  localparam int CMD_ACK  = 3;
  localparam int CMD_IACK = 0;
  localparam int SR_RXACK = 7;
  localparam int SR_BUSY  = 6;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;
  localparam int SR_IRQ   = 0;
  localparam int ISR_DONE = 0;
  localparam int ISR_AL   = 1;
  localparam int ISR_LVL  = 2;
  localparam int ISR_ERR  = 3;
endpackage

// File: rtl/i2c_sync_fifo.sv
// i2c_sync_fifo: single-clock FIFO with flush; when full, a same-cycle pop frees room for the push
module i2c_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = empty ? '0 : mem_q[rp_q];
  assign count = cnt_q;
  always_ff @(posedge clk)
    if (do_push && !flush) mem_q[wp_q] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/i2c_master_csr_fifo.sv
// i2c_master_csr_fifo: APB register front-end for an I2C byte controller with TX/RX FIFOs and sticky, maskable interrupts
module i2c_master_csr_fifo
  import i2c_master_pkg::*;
#(
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter logic [15:0] PRER_RST   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        apb_sel,
  input  logic        apb_en,
  input  logic        apb_write,
  input  logic [31:0] apb_addr,
  input  logic [31:0] apb_wdata,
  output logic [31:0] apb_rdata,
  output logic        apb_ready,
  output logic        irq,
  output logic        core_en,
  output logic [15:0] prer,
  output logic        sta,
  output logic        sto,
  output logic        rd,
  output logic        wr,
  output logic        ack,
  output logic [7:0]  txr,
  input  logic [7:0]  rxr,
  input  logic        done,
  input  logic        i2c_al,
  input  logic        irxack,
  input  logic        i2c_busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic setup, write_en, read_en, cmd_we, cmd_ok, cmd_rej, irq_pending, unused;
  logic [2:0] a;
  logic [15:0] prer_q;
  logic [1:0] ctr_q;
  logic [7:0] cr_q, cr_d, sr, tx_dout, rx_dout;
  logic [3:0] ier_q, isr_q, isr_d, isr_set, isr_w1c;
  logic al_q, rxack_q, tip_q, irq_q, flush_q, tx_empty_q, rx_full_q;
  logic [31:0] rdata_q, rdata_d;
  logic tx_push, tx_pop, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
  logic [CW-1:0] tx_cnt, rx_cnt;
  assign unused = ^{apb_addr[31:5], apb_addr[1:0], apb_wdata[31:16]};
  assign a = apb_addr[4:2];
  assign setup = apb_sel & ~apb_en;
  assign write_en = apb_sel & apb_en & apb_write;
  assign read_en = apb_sel & apb_en & ~apb_write;
  assign tx_push = write_en && a == ADDR_DATA;
  assign tx_pop = done & cr_q[CMD_WR];
  assign rx_push = done & cr_q[CMD_RD];
  assign rx_pop = read_en && a == ADDR_DATA;
  assign cmd_we = write_en && a == ADDR_CMD && ctr_q[1];
  assign cmd_rej = cmd_we & apb_wdata[CMD_WR] & tx_empty;
  assign cmd_ok = cmd_we & ~cmd_rej;
  assign irq_pending = |(isr_q & ier_q);
  assign sr = {rxack_q, i2c_busy, al_q, 3'b0, tip_q, irq_pending};
  assign isr_set = {(tx_push & tx_full & ~tx_pop) | (rx_push & rx_full & ~rx_pop) | (rx_pop & rx_empty) | cmd_rej,
                    (tx_empty & ~tx_empty_q) | (rx_full & ~rx_full_q), i2c_al, done};
  assign isr_w1c = (write_en && a == ADDR_ISR) ? apb_wdata[3:0] : 4'b0;
  assign isr_d = (cr_q[CMD_IACK] ? 4'b0 : isr_q & ~isr_w1c) | isr_set;
  assign cr_d = cmd_ok ? apb_wdata[7:0] & 8'hF9 :
                flush_q ? 8'b0 : {(done | i2c_al) ? 4'b0 : cr_q[7:4], cr_q[3], 3'b0};
  assign rdata_d = a == ADDR_PRER ? {16'b0, prer_q} :
                   a == ADDR_CTR  ? {24'b0, ctr_q, 6'b0} :
                   a == ADDR_DATA ? {24'b0, rx_dout} :
                   a == ADDR_CMD  ? {24'b0, sr} :
                   a == ADDR_IER  ? {28'b0, ier_q} :
                   a == ADDR_ISR  ? {28'b0, isr_q} :
                   a == ADDR_LVL  ? {16'b0, 8'(rx_cnt), 8'(tx_cnt)} : 32'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prer_q <= PRER_RST;
      ctr_q <= '0;
      ier_q <= '0;
      cr_q <= '0;
      isr_q <= '0;
      al_q <= 1'b0;
      rxack_q <= 1'b0;
      tip_q <= 1'b0;
      irq_q <= 1'b0;
      flush_q <= 1'b0;
      tx_empty_q <= 1'b1;
      rx_full_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (write_en && a == ADDR_PRER) prer_q <= apb_wdata[15:0];
      if (write_en && a == ADDR_CTR) ctr_q <= apb_wdata[7:6];
      if (write_en && a == ADDR_IER) ier_q <= apb_wdata[3:0];
      if (setup) rdata_q <= rdata_d;
      flush_q <= write_en && a == ADDR_CTR && ctr_q[1] && !apb_wdata[7];
      cr_q <= cr_d;
      isr_q <= isr_d;
      al_q <= i2c_al | (al_q & ~cr_q[CMD_STA]);
      rxack_q <= irxack;
      tip_q <= cr_q[CMD_RD] | cr_q[CMD_WR];
      irq_q <= ctr_q[0] & irq_pending;
      tx_empty_q <= tx_empty;
      rx_full_q <= rx_full;
    end
  i2c_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .flush(flush_q), .din(apb_wdata[7:0]),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_cnt)
  );
  i2c_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop), .flush(flush_q), .din(rxr),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_cnt)
  );
  assign apb_rdata = rdata_q;
  assign apb_ready = 1'b1;
  assign irq = irq_q;
  assign core_en = ctr_q[1];
  assign prer = prer_q;
  assign {sta, sto, rd, wr, ack} = cr_q[7:3];
  assign txr = tx_dout;
endmodule

// File: tb/tb_i2c_master_csr_fifo.sv
// tb_i2c_master_csr_fifo: directed scenario tasks for the I2C CSR/FIFO block
module tb_i2c_master_csr_fifo;
  logic clk = 0, rst_n = 0, apb_sel = 0, apb_en = 0, apb_write = 0;
  logic [31:0] apb_addr = 0, apb_wdata = 0, apb_rdata;
  logic apb_ready, irq, core_en, sta, sto, rd, wr, ack;
  logic done = 0, i2c_al = 0, irxack = 0, i2c_busy = 0;
  logic [15:0] prer;
  logic [7:0] txr, rxr = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  i2c_master_csr_fifo #(.FIFO_DEPTH(8), .PRER_RST(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .apb_sel(apb_sel), .apb_en(apb_en), .apb_write(apb_write),
    .apb_addr(apb_addr), .apb_wdata(apb_wdata), .apb_rdata(apb_rdata), .apb_ready(apb_ready),
    .irq(irq), .core_en(core_en), .prer(prer), .sta(sta), .sto(sto), .rd(rd), .wr(wr), .ack(ack),
    .txr(txr), .rxr(rxr), .done(done), .i2c_al(i2c_al), .irxack(irxack), .i2c_busy(i2c_busy)
  );
  task cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task apb_wr(input logic [31:0] a, input logic [31:0] d);
    apb_sel = 1; apb_en = 0; apb_write = 1; apb_addr = a; apb_wdata = d;
    cyc(1);
    apb_en = 1;
    cyc(1);
    apb_sel = 0; apb_en = 0; apb_write = 0;
  endtask
  task apb_rd(input logic [31:0] a, output logic [31:0] d);
    apb_sel = 1; apb_en = 0; apb_write = 0; apb_addr = a;
    cyc(1);
    apb_en = 1;
    d = apb_rdata;
    cyc(1);
    apb_sel = 0; apb_en = 0;
  endtask
  task pulse_done(input logic [7:0] b);
    rxr = b; done = 1;
    cyc(1);
    done = 0;
  endtask
  task test_reset;
    logic [31:0] d;
    rst_n = 0;
    cyc(3);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    rst_n = 1;
    cyc(1);
    apb_rd(32'h00, d);
    checks++; if (d !== 32'h0000FFFF) begin errors++; $display("FAIL reset_prer got %h want 0000ffff", d); end
    apb_rd(32'h18, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_lvl got %h want 0", d); end
    apb_rd(32'h0C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_sr got %h want 0", d); end
    apb_rd(32'h14, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_isr got %h want 0", d); end
  endtask
  task test_cmd_done;
    logic [31:0] d;
    apb_wr(32'h04, 32'hC0);
    apb_wr(32'h10, 32'h1);
    apb_wr(32'h08, 32'hA5);
    apb_wr(32'h08, 32'h3C);
    apb_wr(32'h0C, 32'h90);
    checks++; if (txr !== 8'hA5) begin errors++; $display("FAIL cmd_txr got %h want a5", txr); end
    checks++; if ({sta, wr} !== 2'b11) begin errors++; $display("FAIL cmd_sta_wr got %b want 11", {sta, wr}); end
    pulse_done(8'h00);
    checks++; if (txr !== 8'h3C) begin errors++; $display("FAIL done_txr got %h want 3c", txr); end
    checks++; if ({sta, sto, rd, wr} !== 4'b0) begin errors++; $display("FAIL done_cr got %b want 0000", {sta, sto, rd, wr}); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL done_irq_early got %b want 0", irq); end
    cyc(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL done_irq got %b want 1", irq); end
    apb_rd(32'h14, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL done_isr got %h want 1", d); end
    apb_wr(32'h14, 32'h1);
    cyc(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got %b want 0", irq); end
  endtask
  task test_tx_full;
    logic [31:0] d;
    apb_wr(32'h04, 32'h40);
    apb_wr(32'h04, 32'hC0);
    apb_wr(32'h14, 32'hF);
    for (int i = 1; i <= 9; i++) apb_wr(32'h08, i);
    apb_rd(32'h18, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL full_lvl got %h want 8", d); end
    apb_rd(32'h14, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL full_isr got %h want 8", d); end
    apb_wr(32'h14, 32'hF);
    apb_wr(32'h0C, 32'h10);
    checks++; if (wr !== 1'b1) begin errors++; $display("FAIL full_wr got %b want 1", wr); end
    apb_sel = 1; apb_en = 0; apb_write = 1; apb_addr = 32'h08; apb_wdata = 32'hAA;
    cyc(1);
    apb_en = 1; done = 1;
    cyc(1);
    apb_sel = 0; apb_en = 0; apb_write = 0; done = 0;
    checks++; if (txr !== 8'h02) begin errors++; $display("FAIL pushpop_txr got %h want 02", txr); end
    apb_rd(32'h18, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL pushpop_lvl got %h want 8", d); end
    apb_rd(32'h14, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL pushpop_isr got %h want 1", d); end
  endtask
  task test_rx;
    logic [31:0] d;
    logic [7:0] vals [3];
    vals = '{8'h11, 8'h22, 8'h33};
    apb_wr(32'h04, 32'h40);
    apb_wr(32'h04, 32'hC0);
    apb_wr(32'h14, 32'hF);
    apb_wr(32'h0C, 32'h10);
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reject_wr got %b want 0", wr); end
    apb_rd(32'h14, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL reject_isr got %h want 8", d); end
    apb_wr(32'h14, 32'hF);
    for (int i = 0; i < 3; i++) begin
      apb_wr(32'h0C, 32'h20);
      pulse_done(vals[i]);
    end
    apb_rd(32'h18, d);
    checks++; if (d !== 32'h300) begin errors++; $display("FAIL rx_lvl got %h want 300", d); end
    for (int i = 0; i < 3; i++) begin
      apb_rd(32'h08, d);
      checks++; if (d !== {24'b0, vals[i]}) begin errors++; $display("FAIL rx_data%0d got %h want %h", i, d, vals[i]); end
    end
    apb_rd(32'h08, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_empty_data got %h want 0", d); end
    apb_rd(32'h14, d);
    checks++; if (d[3] !== 1'b1) begin errors++; $display("FAIL rx_underflow got %b want 1", d[3]); end
  endtask
  task test_al;
    logic [31:0] d;
    apb_wr(32'h08, 32'h55);
    apb_wr(32'h0C, 32'h90);
    i2c_al = 1;
    cyc(1);
    i2c_al = 0;
    checks++; if ({sta, sto, rd, wr} !== 4'b0) begin errors++; $display("FAIL al_cr got %b want 0000", {sta, sto, rd, wr}); end
    apb_rd(32'h0C, d);
    checks++; if (d[5] !== 1'b1) begin errors++; $display("FAIL al_sr got %b want 1", d[5]); end
    apb_rd(32'h14, d);
    checks++; if (d[1] !== 1'b1) begin errors++; $display("FAIL al_isr got %b want 1", d[1]); end
    apb_wr(32'h0C, 32'h80);
    checks++; if (sta !== 1'b1) begin errors++; $display("FAIL al_sta got %b want 1", sta); end
    cyc(1);
    apb_rd(32'h0C, d);
    checks++; if (d[5] !== 1'b0) begin errors++; $display("FAIL al_clear got %b want 0", d[5]); end
  endtask
  task test_reset_mid;
    logic [31:0] d;
    apb_wr(32'h04, 32'h40);
    apb_wr(32'h04, 32'hC0);
    for (int i = 0; i < 5; i++) apb_wr(32'h08, 32'h60 + i);
    apb_wr(32'h10, 32'hF);
    cyc(2);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mid_irq_pre got %b want 1", irq); end
    apb_rd(32'h18, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL mid_lvl_pre got %h want 5", d); end
    rst_n = 0;
    #2;
    checks++; if (dut.u_tx_fifo.count !== 4'd0) begin errors++; $display("FAIL mid_txcnt got %0d want 0", dut.u_tx_fifo.count); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq got %b want 0", irq); end
    checks++; if (txr !== 8'h0) begin errors++; $display("FAIL mid_txr got %h want 0", txr); end
    cyc(1);
    rst_n = 1;
    cyc(1);
    apb_rd(32'h18, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_lvl got %h want 0", d); end
  endtask
  initial begin
    test_reset;
    test_cmd_done;
    test_tx_full;
    test_rx;
    test_al;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
